// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive path.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int DEF_OVERSAMP = 16;
    localparam int DEF_DEPTH    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Value the parity bit must carry for the frame to hold an even number of ones
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl_if
// Brief    : Line/tick inputs and LSU-facing status/data of the UART receiver.
// Config   : UART_RX_PARITY_EN adds parity_err
// Revision : 1.0
// ============================================================================
interface uart_rx_fifo_ctrl_if;
    import uart_pkg::*;

    logic                   baud_tick;
    logic                   rx_serial;
    logic                   rd_en;
    logic                   err_clr;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rxfe;
    logic                   rxff;
    logic                   frame_err;
    logic                   overrun_err;

`ifdef UART_RX_PARITY_EN
    logic                   parity_err;

    modport master (
        output baud_tick, rx_serial, rd_en, err_clr,
        input  rx_data, rxfe, rxff, frame_err, overrun_err, parity_err
    );
    modport slave (
        input  baud_tick, rx_serial, rd_en, err_clr,
        output rx_data, rxfe, rxff, frame_err, overrun_err, parity_err
    );
`else
    modport master (
        output baud_tick, rx_serial, rd_en, err_clr,
        input  rx_data, rxfe, rxff, frame_err, overrun_err
    );
    modport slave (
        input  baud_tick, rx_serial, rd_en, err_clr,
        output rx_data, rxfe, rxff, frame_err, overrun_err
    );
`endif

endinterface
`default_nettype wire

// File: rtl/rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_byte_fifo
// Brief    : Show-ahead byte FIFO; head reads as zero while empty.
// Revision : 1.0
// ============================================================================
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never frees room for a push that was already refused.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl
// Brief    : Oversampling UART receiver (8N1) feeding an 8-deep byte FIFO.
// Config   : UART_RX_PARITY_EN selects 8E1 framing with a sticky parity_err
// Revision : 1.0
// ============================================================================
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int OVERSAMP = DEF_OVERSAMP
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_fifo_ctrl_if.slave  bus
);

    localparam int                TICK_W    = $clog2(OVERSAMP);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMP/2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMP - 1);

    logic                   sync1;
    logic                   sync2;
    logic                   sync3;
    logic                   rx_sync;
    logic                   fall_edge;

    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [TICK_W-1:0]      tick_q;
    logic [TICK_W-1:0]      tick_d;
    logic [2:0]             bit_q;
    logic [2:0]             bit_d;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] shift_d;

    logic                   push_req;
    logic                   set_frame;
    logic                   set_overrun;
    logic                   byte_ok;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_head;
    logic                   frame_err_q;
    logic                   overrun_err_q;

`ifdef UART_RX_PARITY_EN
    logic                   par_ok_q;
    logic                   par_ok_d;
    logic                   set_parity;
    logic                   parity_err_q;

    assign byte_ok = par_ok_q;
`else
    assign byte_ok = 1'b1;
`endif

    // Flops idle high so reset never fabricates a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= bus.rx_serial;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_sync   = sync2;
    assign fall_edge = sync3 & ~sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= par_ok_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        set_frame   = 1'b0;
        set_overrun = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d    = par_ok_q;
        set_parity  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_sync ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.baud_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_sync, shift_q[UART_DATA_W-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.baud_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d     = '0;
                        par_ok_d   = (rx_sync == even_parity(shift_q));
                        set_parity = (rx_sync != even_parity(shift_q));
                        state_d    = STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.baud_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (!rx_sync) begin
                            set_frame = 1'b1;
                        end else if (byte_ok) begin
                            if (fifo_full) begin
                                set_overrun = 1'b1;
                            end else begin
                                push_req = 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            if (set_frame) begin
                frame_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (set_overrun) begin
                overrun_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_err_q <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (set_parity) begin
                parity_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                parity_err_q <= 1'b0;
            end
`endif
        end
    end

    rx_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (bus.rd_en),
        .din   (shift_q),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rx_data     = fifo_head;
    assign bus.rxfe        = fifo_empty;
    assign bus.rxff        = fifo_full;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo_ctrl
// Brief    : Directed self-checking bench for uart_rx_fifo_ctrl (UART_RX_PARITY_EN aware).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo_ctrl;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   div      = 2;
    int   tick_cnt = 0;
    int   checks   = 0;
    int   fails    = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo_ctrl_if bus();

    uart_rx_fifo_ctrl #(
        .DEPTH    (8),
        .OVERSAMP (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // baud_tick every div clocks; div = 1 keeps it high so edges are countable
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt      = tick_cnt + 1;
            bus.baud_tick = (div == 1) || (tick_cnt % div == 0);
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        bus.rx_serial = v;
        repeat (16*div - 1) @(negedge clk);
    endtask

    task automatic frame_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        frame_head(d);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check8(tag, bus.rx_data, exp);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    // div == 1 only: stop sample lands on the 11th rising edge after the stop bit
    // is driven; rd/clr are held across exactly that edge, then sampled #1 after.
    task automatic stop_edge(input logic stop_v, input logic rd, input logic clr,
                             input logic pre_rxfe);
        @(negedge clk);
        bus.rx_serial = stop_v;
        repeat (10) @(posedge clk);
        #1;
        check1("pre_stop_rxfe", bus.rxfe, pre_rxfe);
        @(negedge clk);
        bus.rd_en   = rd;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.rx_serial = 1'b1;
        bus.rd_en     = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check1("reset_rxfe", bus.rxfe, 1'b1);
        check1("reset_rxff", bus.rxff, 1'b0);
        check8("reset_rx_data", bus.rx_data, 8'h00);
        check1("reset_frame_err", bus.frame_err, 1'b0);
        check1("reset_overrun_err", bus.overrun_err, 1'b0);
        reset = 1'b0;

        // 0xA5 with exact push latency
        div = 1;
        repeat (20) @(negedge clk);
        frame_head(8'hA5);
        stop_edge(1'b1, 1'b0, 1'b0, 1'b1);
        check1("a5_rxfe_after_push", bus.rxfe, 1'b0);
        check8("a5_rx_data", bus.rx_data, 8'hA5);
        repeat (17) @(negedge clk);
        pop_expect("a5_pop", 8'hA5);
        check1("a5_empty_after_pop", bus.rxfe, 1'b1);
        check8("a5_zero_after_pop", bus.rx_data, 8'h00);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check1("rd_empty_rxfe", bus.rxfe, 1'b1);
        check1("rd_empty_rxff", bus.rxff, 1'b0);

        // 4-tick glitch on idle line
        div = 2;
        repeat (8) @(negedge clk);
        bus.rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        bus.rx_serial = 1'b1;
        repeat (400) @(negedge clk);
        check1("glitch_rxfe", bus.rxfe, 1'b1);
        check1("glitch_frame_err", bus.frame_err, 1'b0);
        check1("glitch_overrun_err", bus.overrun_err, 1'b0);

        // 0x3C with low stop bit, err_clr in the same cycle, then a held break
        div = 1;
        repeat (20) @(negedge clk);
        frame_head(8'h3C);
        stop_edge(1'b0, 1'b0, 1'b1, 1'b1);
        check1("ferr_beats_clr", bus.frame_err, 1'b1);
        check1("ferr_fifo_empty", bus.rxfe, 1'b1);
        @(negedge clk);
        bus.err_clr = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        check1("ferr_sticky", bus.frame_err, 1'b1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check1("ferr_cleared", bus.frame_err, 1'b0);
        for (int i = 0; i < 12; i++) drive_bit(1'b0);
        check1("break_no_frame_err", bus.frame_err, 1'b0);
        check1("break_fifo_empty", bus.rxfe, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // nine bytes without reads
        div = 2;
        repeat (8) @(negedge clk);
        for (int i = 1; i <= 8; i++) send_frame(8'(i));
        check1("fill_rxff", bus.rxff, 1'b1);
        check1("fill_no_overrun", bus.overrun_err, 1'b0);
        send_frame(8'h09);
        check1("ninth_overrun", bus.overrun_err, 1'b1);
        check1("ninth_rxff", bus.rxff, 1'b1);
        for (int i = 1; i <= 8; i++) pop_expect("ovr_pop", 8'(i));
        check1("ovr_drained_rxfe", bus.rxfe, 1'b1);
        check8("ovr_drained_data", bus.rx_data, 8'h00);

        // full FIFO popped in the stop-sample cycle, then push+pop together
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check1("overrun_cleared", bus.overrun_err, 1'b0);
        div = 1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
        check1("refill_rxff", bus.rxff, 1'b1);
        frame_head(8'h99);
        stop_edge(1'b1, 1'b1, 1'b0, 1'b0);
        check1("fullpop_overrun", bus.overrun_err, 1'b1);
        check1("fullpop_rxff", bus.rxff, 1'b0);
        check8("fullpop_head", bus.rx_data, 8'h11);
        @(negedge clk);
        bus.rd_en = 1'b0;
        repeat (16) @(negedge clk);
        frame_head(8'h42);
        stop_edge(1'b1, 1'b1, 1'b0, 1'b0);
        check1("pushpop_rxff", bus.rxff, 1'b0);
        check8("pushpop_head", bus.rx_data, 8'h12);
        @(negedge clk);
        bus.rd_en = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 2; i < 8; i++) pop_expect("pushpop_drain", 8'h10 + 8'(i));
        pop_expect("pushpop_last", 8'h42);
        check1("pushpop_empty", bus.rxfe, 1'b1);

        // reset in the middle of a frame
        div = 2;
        repeat (8) @(negedge clk);
        send_frame(8'h77);
        check8("pre_reset_data", bus.rx_data, 8'h77);
        check1("pre_reset_overrun", bus.overrun_err, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        #3;
        reset = 1'b1;
        #1;
        check1("midreset_rxfe", bus.rxfe, 1'b1);
        check8("midreset_data", bus.rx_data, 8'h00);
        check1("midreset_overrun", bus.overrun_err, 1'b0);
        check1("midreset_rxff", bus.rxff, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        send_frame(8'h5A);
        check1("after_reset_rxfe", bus.rxfe, 1'b0);
        pop_expect("after_reset_5a", 8'h5A);
        check1("after_reset_frame_err", bus.frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07);
        check1("parity_bad_flag", bus.parity_err, 1'b1);
        check1("parity_bad_dropped", bus.rxfe, 1'b1);
        par_flip = 1'b0;
        send_frame(8'h07);
        pop_expect("parity_good_data", 8'h07);
        check1("parity_sticky", bus.parity_err, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
